// File: rtl/writeback_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : writeback_regfile                                            |
// | Description : Write-back stage and 16x20-bit architectural register file   |
// |               for the 20-bit pipeline. Selects the write-back value by     |
// |               opcode, commits it, serves two combinational read ports and  |
// |               counts retired valid instructions.                           |
// |               Optional feature macro: WB_BYPASS_EN (write-through bypass   |
// |               of the value being written onto the read ports).             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module writeback_regfile #(
  parameter int DATA_W    = 20,
  parameter int REG_COUNT = 16,
  parameter int CNT_W     = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [DATA_W-1:0]            instruction,
  input  logic                         instr_valid,
  input  logic [DATA_W-1:0]            aluRESULTout,
  input  logic [DATA_W-1:0]            memory_read_data_out,
  input  logic [$clog2(REG_COUNT)-1:0] read_reg_a,
  input  logic [$clog2(REG_COUNT)-1:0] read_reg_b,
  output logic [DATA_W-1:0]            read_data_a,
  output logic [DATA_W-1:0]            read_data_b,
  output logic                         wb_write,
  output logic [$clog2(REG_COUNT)-1:0] wb_reg,
  output logic [DATA_W-1:0]            wb_data,
  output logic [CNT_W-1:0]             retired_count
);

  localparam int          c_IDX_W   = $clog2(REG_COUNT);
  localparam logic [3:0]  c_OP_LOAD = 4'h0;

  logic [3:0]         w_opcode;
  logic [c_IDX_W-1:0] w_rd;
  logic               w_writes_class;
  logic [DATA_W-1:0]  w_wb_value;
  logic [DATA_W-1:0]  w_stored_a;
  logic [DATA_W-1:0]  w_stored_b;
  logic               w_unused_bits;

  logic [DATA_W-1:0]  r_regs [REG_COUNT];
  logic [CNT_W-1:0]   r_retired;

  assign w_opcode      = instruction[DATA_W-1 -: 4];
  assign w_rd          = instruction[DATA_W-5 -: c_IDX_W];
  // Remaining instruction bits (source fields, immediates) are consumed upstream.
  assign w_unused_bits = ^instruction[DATA_W-5-c_IDX_W:0];

  // Opcode class decode: LOAD and the ALU group (2..7) write, everything else does not.
  always_comb begin
    w_writes_class = 1'b0;
    case (w_opcode)
      4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: w_writes_class = 1'b1;
      default:                                   w_writes_class = 1'b0;
    endcase
  end

  // Write-back value mux: loads take memory data, all other opcodes take the ALU result.
  always_comb begin
    w_wb_value = aluRESULTout;
    if (w_opcode == c_OP_LOAD) begin
      w_wb_value = memory_read_data_out;
    end
  end

  assign wb_write = instr_valid & w_writes_class & (w_rd != '0);
  assign wb_reg   = w_rd;
  assign wb_data  = w_wb_value;

  // Register file commit; reset clears every entry and wins over a same-cycle write.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wb_write) begin
      r_regs[w_rd] <= wb_data;
    end
  end

  // Retired-instruction counter: every valid slot retires, writing or not; wraps naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_retired <= '0;
    end else if (instr_valid) begin
      r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign retired_count = r_retired;

  // Stored-value read: index 0 is hard-wired to zero regardless of array contents.
  always_comb begin
    w_stored_a = (read_reg_a == '0) ? '0 : r_regs[read_reg_a];
    w_stored_b = (read_reg_b == '0) ? '0 : r_regs[read_reg_b];
  end

`ifdef WB_BYPASS_EN
  // Write-through: a read of the register being written sees the new value this cycle.
  // wb_write already excludes index 0, so R0 still reads zero.
  always_comb begin
    read_data_a = w_stored_a;
    read_data_b = w_stored_b;
    if (wb_write && (read_reg_a == wb_reg)) begin
      read_data_a = wb_data;
    end
    if (wb_write && (read_reg_b == wb_reg)) begin
      read_data_b = wb_data;
    end
  end
`else
  // No bypass: the new value becomes visible the cycle after the committing edge.
  always_comb begin
    read_data_a = w_stored_a;
    read_data_b = w_stored_b;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_writeback_regfile                                         |
// | Description : Self-checking bench for writeback_regfile: vector table plus |
// |               hand-written multi-cycle sequences, scoreboard queue of      |
// |               expected outputs compared just after inputs settle.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_writeback_regfile;

  logic        clock;
  logic        reset;
  logic [19:0] instruction;
  logic        instr_valid;
  logic [19:0] aluRESULTout;
  logic [19:0] memory_read_data_out;
  logic [3:0]  read_reg_a;
  logic [3:0]  read_reg_b;
  logic [19:0] read_data_a;
  logic [19:0] read_data_b;
  logic        wb_write;
  logic [3:0]  wb_reg;
  logic [19:0] wb_data;
  logic [15:0] retired_count;

  writeback_regfile dut (
    .clock                (clock),
    .reset                (reset),
    .instruction          (instruction),
    .instr_valid          (instr_valid),
    .aluRESULTout         (aluRESULTout),
    .memory_read_data_out (memory_read_data_out),
    .read_reg_a           (read_reg_a),
    .read_reg_b           (read_reg_b),
    .read_data_a          (read_data_a),
    .read_data_b          (read_data_b),
    .wb_write             (wb_write),
    .wb_reg               (wb_reg),
    .wb_data              (wb_data),
    .retired_count        (retired_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [19:0] instr;
    logic        valid;
    logic [19:0] alu;
    logic [19:0] mem;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        exp_we;
    logic [19:0] exp_data;
  } vec_t;

  typedef struct {
    int          kind;
    logic [31:0] exp;
  } sb_t;

  sb_t         sb [$];
  int          checks = 0;
  int          errors = 0;
  logic [19:0] m_regs [16];
  logic [15:0] m_cnt = '0;
  vec_t        tbl [12];

  // Reference of a read port: zero for R0, optional bypass, else model contents.
  function automatic logic [19:0] exp_read(input logic [3:0] idx, input logic we,
                                           input logic [3:0] rd, input logic [19:0] d);
    if (idx == 4'd0) return 20'h0;
`ifdef WB_BYPASS_EN
    if (we && idx == rd) return d;
`endif
    return m_regs[idx];
  endfunction

  function automatic logic [31:0] actual(input int kind);
    case (kind)
      0: return {31'h0, wb_write};
      1: return {28'h0, wb_reg};
      2: return {12'h0, wb_data};
      3: return {12'h0, read_data_a};
      4: return {12'h0, read_data_b};
      default: return {16'h0, retired_count};
    endcase
  endfunction

  function automatic string kname(input int kind);
    case (kind)
      0: return "wb_write";
      1: return "wb_reg";
      2: return "wb_data";
      3: return "read_data_a";
      4: return "read_data_b";
      default: return "retired_count";
    endcase
  endfunction

  // One clock cycle: drive at negedge, queue expectations, compare, then commit model.
  task automatic step(input logic rst_i, input logic [19:0] ins, input logic v,
                      input logic [19:0] alu, input logic [19:0] mem,
                      input logic [3:0] ra, input logic [3:0] rb,
                      input logic ewe, input logic [19:0] ed, input bit chk);
    logic [3:0] rd;
    sb_t        it;
    rd = ins[15:12];
    @(negedge clock);
    reset = rst_i; instruction = ins; instr_valid = v;
    aluRESULTout = alu; memory_read_data_out = mem;
    read_reg_a = ra; read_reg_b = rb;
    if (chk) begin
      sb.push_back('{0, {31'h0, ewe}});
      sb.push_back('{1, {28'h0, rd}});
      sb.push_back('{2, {12'h0, ed}});
      sb.push_back('{3, {12'h0, exp_read(ra, ewe, rd, ed)}});
      sb.push_back('{4, {12'h0, exp_read(rb, ewe, rd, ed)}});
      sb.push_back('{5, {16'h0, m_cnt}});
      #1;
      while (sb.size() > 0) begin
        it = sb.pop_front();
        checks++;
        if (actual(it.kind) !== it.exp) begin
          errors++;
          $display("FAIL %s @%0t: got %0h expected %0h", kname(it.kind), $time,
                   actual(it.kind), it.exp);
        end
      end
    end
    @(posedge clock);
    if (rst_i) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 20'h0;
      m_cnt = '0;
    end else begin
      if (ewe) m_regs[rd] = ed;
      if (v) m_cnt = m_cnt + 16'd1;
    end
  endtask

  // Spec-level write decision for hand-written sequences.
  function automatic logic m_we(input logic v, input logic [19:0] ins);
    logic [3:0] op;
    op = ins[19:16];
    return v && (ins[15:12] != 4'd0) && (op == 4'h0 || (op >= 4'h2 && op <= 4'h7));
  endfunction

  initial begin
    logic [19:0] ins;
    logic [19:0] d;
    for (int i = 0; i < 16; i++) m_regs[i] = 20'h0;
    reset = 1'b1; instruction = '0; instr_valid = 1'b0;
    aluRESULTout = '0; memory_read_data_out = '0; read_reg_a = '0; read_reg_b = '0;

    // Reset state with all-zero inputs.
    step(1'b1, 20'h0, 1'b0, 20'h0, 20'h0, 4'd0, 4'd0, 1'b0, 20'h0, 1'b0);
    step(1'b1, 20'h0, 1'b0, 20'h0, 20'h0, 4'd0, 4'd0, 1'b0, 20'h0, 1'b1);

    // instr, valid, alu, mem, ra, rb, exp_we, exp_data
    tbl[0]  = '{20'h25000, 1'b1, 20'hABCDE, 20'h00000, 4'd5, 4'd0, 1'b1, 20'hABCDE};
    tbl[1]  = '{20'hF0000, 1'b0, 20'h00000, 20'h00000, 4'd5, 4'd5, 1'b0, 20'h00000};
    tbl[2]  = '{20'h03000, 1'b1, 20'hFFFFF, 20'h12345, 4'd3, 4'd5, 1'b1, 20'h12345};
    tbl[3]  = '{20'h13000, 1'b1, 20'h11111, 20'h11111, 4'd3, 4'd3, 1'b0, 20'h11111};
    tbl[4]  = '{20'h20000, 1'b1, 20'h00001, 20'h00001, 4'd0, 4'd3, 1'b0, 20'h00001};
    tbl[5]  = '{20'h26000, 1'b0, 20'h77777, 20'h77777, 4'd6, 4'd0, 1'b0, 20'h77777};
    tbl[6]  = '{20'h84000, 1'b1, 20'h55555, 20'h55555, 4'd4, 4'd6, 1'b0, 20'h55555};
    tbl[7]  = '{20'h94000, 1'b1, 20'h66666, 20'h66666, 4'd4, 4'd3, 1'b0, 20'h66666};
    tbl[8]  = '{20'h7F000, 1'b1, 20'h3C3C3, 20'h00000, 4'd5, 4'd15, 1'b1, 20'h3C3C3};
    tbl[9]  = '{20'hF0000, 1'b1, 20'h00000, 20'h00000, 4'd15, 4'd15, 1'b0, 20'h00000};
    tbl[10] = '{20'h00000, 1'b1, 20'h00000, 20'hABCDE, 4'd0, 4'd5, 1'b0, 20'hABCDE};
    tbl[11] = '{20'hF0000, 1'b1, 20'h00000, 20'h00000, 4'd3, 4'd0, 1'b0, 20'h00000};
    for (int i = 0; i < 12; i++) begin
      step(1'b0, tbl[i].instr, tbl[i].valid, tbl[i].alu, tbl[i].mem,
           tbl[i].ra, tbl[i].rb, tbl[i].exp_we, tbl[i].exp_data, 1'b1);
    end

    // Same-cycle hazard on R7: old 00011, new 0F0F0 read on port B.
    step(1'b0, 20'h27000, 1'b1, 20'h00011, 20'h0, 4'd0, 4'd0, 1'b1, 20'h00011, 1'b1);
    step(1'b0, 20'h27000, 1'b1, 20'h0F0F0, 20'h0, 4'd7, 4'd7, 1'b1, 20'h0F0F0, 1'b1);
    step(1'b0, 20'hF0000, 1'b0, 20'h0, 20'h0, 4'd7, 4'd7, 1'b0, 20'h0, 1'b1);

    // Random writes, two idle cycles, then reset: everything returns to zero.
    for (int i = 0; i < 4; i++) begin
      ins = {4'h2, 4'($urandom_range(1, 15)), 12'h0};
      d   = 20'($urandom);
      step(1'b0, ins, 1'b1, d, 20'h0, ins[15:12], 4'd7, m_we(1'b1, ins), d, 1'b1);
    end
    step(1'b0, 20'hF0000, 1'b1, 20'h0, 20'h0, 4'd1, 4'd2, 1'b0, 20'h0, 1'b1);
    step(1'b0, 20'hF0000, 1'b1, 20'h0, 20'h0, 4'd3, 4'd4, 1'b0, 20'h0, 1'b1);
    step(1'b1, 20'h0, 1'b0, 20'h0, 20'h0, 4'd0, 4'd0, 1'b0, 20'h0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 20'hF0000, 1'b0, 20'h0, 20'h0, 4'(i), 4'(15 - i), 1'b0, 20'h0, 1'b1);
    end

    // Write to R9 presented during reset is discarded; wb_write still follows inputs.
    step(1'b0, 20'h29000, 1'b1, 20'h00999, 20'h0, 4'd9, 4'd0, 1'b1, 20'h00999, 1'b1);
    step(1'b1, 20'h29000, 1'b1, 20'h12345, 20'h0, 4'd9, 4'd9, 1'b1, 20'h12345, 1'b1);
    step(1'b0, 20'hF0000, 1'b0, 20'h0, 20'h0, 4'd9, 4'd9, 1'b0, 20'h0, 1'b1);

    // Counter wrap: 65535 valid NOPs, observe FFFF, one more gives 0000.
    for (int i = 0; i < 65535; i++) begin
      step(1'b0, 20'hF0000, 1'b1, 20'h0, 20'h0, 4'd0, 4'd0, 1'b0, 20'h0, 1'b0);
    end
    step(1'b0, 20'hF0000, 1'b1, 20'h0, 20'h0, 4'd0, 4'd0, 1'b0, 20'h0, 1'b1);
    step(1'b0, 20'hF0000, 1'b0, 20'h0, 20'h0, 4'd0, 4'd0, 1'b0, 20'h0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
